// File: rtl/channel_state_ram.sv
// Channel-state RAM: one read port, one masked write port, and a zero-fill
// sequencer that runs after reset and on request.
module channel_state_ram #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 121,
  parameter  int LANE  = 8,
  localparam int MW    = (WIDTH + LANE - 1) / LANE,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [MW-1:0]    wr_mask,
  input  logic             clear_start,
  output logic             busy,
  output logic [AW-1:0]    dbg_ccnt
);

  // Handshake: a read is taken whenever rd_en=1 and busy=0; rd_valid=1 the
  // next cycle marks rd_data as its result. There is no backpressure.
  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     ccnt_q, ccnt_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              idle;
  logic              wr_hit;
  logic              rd_acc;
  logic [WIDTH-1:0]  lane_bits;
  logic [WIDTH-1:0]  rd_word;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_wbits;

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < WIDTH; i++) lane_bits[i] = wr_mask[i / LANE];
  end

  assign idle    = (state_q == S_IDLE);
  assign wr_hit  = idle && wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_acc  = idle && rd_en;
  assign rd_word = mem_q[rd_addr];

  // The sequencer owns the write port while clearing.
  always_comb begin
    mem_we    = wr_hit || !idle;
    mem_waddr = idle ? wr_addr : ccnt_q;
    mem_wdata = idle ? wr_data : '0;
    mem_wbits = idle ? lane_bits : '1;
  end

  // Write-first on collision: merge the incoming lanes into the old word.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) begin
      if ({1'b0, rd_addr} >= DEPTH_W) begin
        rd_data_d = '0;
      end else if (wr_hit && (wr_addr == rd_addr)) begin
        rd_data_d = (rd_word & ~lane_bits) | (wr_data & lane_bits);
      end else begin
        rd_data_d = rd_word;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ccnt_d  = ccnt_q;
    case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          state_d = S_CLEAR;
          ccnt_d  = '0;
        end
      end
      S_CLEAR: begin
        if (ccnt_q == LAST) begin
          state_d = S_IDLE;
          ccnt_d  = '0;
        end else begin
          ccnt_d = ccnt_q + AW'(1);
        end
      end
      default: begin
        state_d = S_CLEAR;
        ccnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      ccnt_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ccnt_q     <= ccnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Entries are not reset; the reset-time zero-fill covers them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (mem_wbits[b]) mem_q[mem_waddr][b] <= mem_wdata[b];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == S_CLEAR);
  assign dbg_ccnt = ccnt_q;

endmodule

// File: tb/tb_channel_state_ram.sv
// Bench for channel_state_ram: vector table, corner sequences, random traffic
// against a behavioural model, plus a DEPTH=6 instance.
module tb_channel_state_ram;

  localparam int W  = 121;
  localparam int MW = 16;
  localparam int AW = 3;
  localparam int D  = 8;
  localparam int DB = 6;

  localparam logic [W-1:0] ONES   = '1;
  localparam logic [W-1:0] ZERO   = '0;
  localparam logic [W-1:0] BIT120 = {1'b1, {120{1'b0}}};
  localparam logic [W-1:0] HI113  = {{113{1'b1}}, 8'h00};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;
  logic rst_n_b = 1'b1;

  logic          rd_en, wr_en, clear_start, rd_valid, busy;
  logic [AW-1:0] rd_addr, wr_addr, dbg_ccnt;
  logic [W-1:0]  rd_data, wr_data;
  logic [MW-1:0] wr_mask;

  logic          b_rd_en, b_wr_en, b_clear_start, b_rd_valid, b_busy;
  logic [AW-1:0] b_rd_addr, b_wr_addr, b_dbg_ccnt;
  logic [W-1:0]  b_rd_data, b_wr_data;
  logic [MW-1:0] b_wr_mask;

  channel_state_ram dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .clear_start(clear_start), .busy(busy), .dbg_ccnt(dbg_ccnt)
  );

  channel_state_ram #(.DEPTH(DB)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .wr_en(b_wr_en),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_mask(b_wr_mask),
    .clear_start(b_clear_start), .busy(b_busy), .dbg_ccnt(b_dbg_ccnt)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural model: whole-array clear, write-then-read ordering
  logic [W-1:0] m_mem [D];
  int           m_busy_left;
  logic [W-1:0] m_rd_data;
  logic         m_rd_valid;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] expand(input logic [MW-1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = m[i / 8];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    m_busy_left = D;
    m_rd_data   = '0;
    m_rd_valid  = 1'b0;
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic re, input logic [AW-1:0] ra, input logic we,
                            input logic [AW-1:0] wa, input logic [W-1:0] wd,
                            input logic [MW-1:0] wm, input logic cs);
    logic [W-1:0] bm;
    bm = expand(wm);
    if (m_busy_left > 0) begin
      m_busy_left--;
      m_rd_valid = 1'b0;
    end else begin
      if (we && int'(wa) < D) m_mem[wa] = (m_mem[wa] & ~bm) | (wd & bm);
      m_rd_valid = re;
      if (re) m_rd_data = (int'(ra) < D) ? m_mem[ra] : '0;
      if (cs) begin
        m_busy_left = D;
        for (int i = 0; i < D; i++) m_mem[i] = '0;
      end
    end
  endtask

  // driver: inputs applied at negedge, outputs sampled at the next negedge
  task automatic step(input logic re, input logic [AW-1:0] ra, input logic we,
                      input logic [AW-1:0] wa, input logic [W-1:0] wd,
                      input logic [MW-1:0] wm, input logic cs);
    rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa;
    wr_data = wd; wr_mask = wm; clear_start = cs;
    model_step(re, ra, we, wa, wd, wm, cs);
    if (m_rd_valid) exp_q.push_back(m_rd_data);
    @(posedge clk);
    @(negedge clk);
    check("rd_valid", W'(rd_valid), W'(m_rd_valid));
    check("busy", W'(busy), W'(m_busy_left > 0));
    if (rd_valid) begin
      if (exp_q.size() == 0) check("rd_unexpected", W'(rd_valid), ZERO);
      else check("rd_data", rd_data, exp_q.pop_front());
    end else begin
      exp_q.delete();
      check("rd_data_hold", rd_data, m_rd_data);
    end
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0; clear_start = 1'b0;
    #1;
    check("reset_busy", W'(busy), W'(1'b1));
    check("reset_rd_valid", W'(rd_valid), ZERO);
    check("reset_rd_data", rd_data, ZERO);
    check("reset_ccnt", W'(dbg_ccnt), ZERO);
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("reset_busy_held", W'(busy), W'(1'b1));
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_clear(input string name, input int expected);
    int n;
    n = 0;
    while (busy && n < 50) begin
      idle_step();
      n++;
    end
    check(name, W'(n), W'(expected));
  endtask

  task automatic b_step(input logic re, input logic [AW-1:0] ra, input logic we,
                        input logic [AW-1:0] wa, input logic [W-1:0] wd);
    b_rd_en = re; b_rd_addr = ra; b_wr_en = we; b_wr_addr = wa;
    b_wr_data = wd; b_wr_mask = '1; b_clear_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic          re;
    logic [AW-1:0] ra;
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [MW-1:0] wm;
    logic          ev;
    logic [W-1:0]  ed;
  } vec_t;

  function automatic vec_t mk(input logic re, input logic [AW-1:0] ra, input logic we,
                              input logic [AW-1:0] wa, input logic [W-1:0] wd,
                              input logic [MW-1:0] wm, input logic ev, input logic [W-1:0] ed);
    vec_t v;
    v.re = re; v.ra = ra; v.we = we; v.wa = wa;
    v.wd = wd; v.wm = wm; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  vec_t vt [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] fill;
    rd_en = 0; rd_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_mask = 0; clear_start = 0;
    b_rd_en = 0; b_rd_addr = 0; b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_mask = 0;
    b_clear_start = 0;
    rst_n_b = 1'b0;

    vt[0]  = mk(0, 3'd0, 1, 3'd3, ONES, 16'hFFFF, 0, ZERO);
    vt[1]  = mk(0, 3'd0, 1, 3'd3, ZERO, 16'h0001, 0, ZERO);
    vt[2]  = mk(1, 3'd3, 0, 3'd0, ZERO, 16'h0000, 1, HI113);
    vt[3]  = mk(1, 3'd2, 1, 3'd2, ONES, 16'h8000, 1, BIT120);
    vt[4]  = mk(1, 3'd2, 0, 3'd0, ZERO, 16'h0000, 1, BIT120);
    vt[5]  = mk(1, 3'd5, 0, 3'd0, ZERO, 16'h0000, 1, ZERO);
    vt[6]  = mk(0, 3'd0, 1, 3'd4, ONES, 16'h0003, 0, ZERO);
    vt[7]  = mk(1, 3'd4, 0, 3'd0, ZERO, 16'h0000, 1, W'(16'hFFFF));
    vt[8]  = mk(1, 3'd4, 1, 3'd4, ONES, 16'h0000, 1, W'(16'hFFFF));
    vt[9]  = mk(0, 3'd0, 0, 3'd0, ZERO, 16'h0000, 0, ZERO);
    vt[10] = mk(1, 3'd6, 1, 3'd6, ONES, 16'h8000, 1, BIT120);

    // power-on clear length
    do_reset(3);
    wait_clear("reset_clear_len", D);

    foreach (vt[i]) begin
      step(vt[i].re, vt[i].ra, vt[i].we, vt[i].wa, vt[i].wd, vt[i].wm, 1'b0);
      check($sformatf("vec%0d_valid", i), W'(rd_valid), W'(vt[i].ev));
      if (vt[i].ev) check($sformatf("vec%0d_data", i), rd_data, vt[i].ed);
    end

    // fill, clear with traffic dropped, then everything reads zero
    for (int a = 0; a < D; a++) begin
      fill = rnd_word() | W'(1);
      step(1'b0, '0, 1'b1, AW'(a), fill, '1, 1'b0);
    end
    for (int a = 0; a < D; a++) step(1'b1, AW'(a), 1'b0, '0, '0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    n = 0;
    while (busy && n < 50) begin
      step(1'b1, AW'($urandom_range(0, D-1)), 1'b1, AW'($urandom_range(0, D-1)),
           rnd_word(), '1, 1'b1);
      n++;
    end
    check("clear_len", W'(n), W'(D));
    for (int a = 0; a < D; a++) begin
      step(1'b1, AW'(a), 1'b0, '0, '0, '0, 1'b0);
      check("cleared_entry", rd_data, ZERO);
    end

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, D-1)),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, D-1)),
           rnd_word(), MW'($urandom_range(0, 65535)),
           1'($urandom_range(0, 39) == 0));
    end
    wait_clear("random_drain", int'(m_busy_left));

    // reset during a clear restarts the full fill
    step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    repeat (3) idle_step();
    do_reset(2);
    wait_clear("reset_mid_clear_len", D);
    step(1'b1, 3'd5, 1'b0, '0, '0, '0, 1'b0);
    check("post_reset_read", rd_data, ZERO);

    // DEPTH=6 instance
    @(negedge clk);
    check("b_reset_busy", W'(b_busy), W'(1'b1));
    check("b_reset_valid", W'(b_rd_valid), ZERO);
    check("b_reset_ccnt", W'(b_dbg_ccnt), ZERO);
    rst_n_b = 1'b1;
    n = 0;
    while (b_busy && n < 50) begin
      b_step(1'b0, '0, 1'b0, '0, '0);
      n++;
    end
    check("b_clear_len", W'(n), W'(DB));
    for (int a = 0; a < DB; a++) b_step(1'b0, '0, 1'b1, AW'(a), W'(a * 3 + 1));
    b_step(1'b0, '0, 1'b1, 3'd6, ONES);
    b_step(1'b0, '0, 1'b1, 3'd7, ONES);
    b_step(1'b1, 3'd7, 1'b0, '0, '0);
    check("b_oob_valid", W'(b_rd_valid), W'(1'b1));
    check("b_oob_data", b_rd_data, ZERO);
    b_step(1'b1, 3'd6, 1'b0, '0, '0);
    check("b_oob6_data", b_rd_data, ZERO);
    for (int a = 0; a < DB; a++) begin
      b_step(1'b1, AW'(a), 1'b0, '0, '0);
      check("b_entry", b_rd_data, W'(a * 3 + 1));
    end
    b_step(1'b0, '0, 1'b0, '0, '0);
    check("b_idle_valid", W'(b_rd_valid), ZERO);
    check("b_hold_data", b_rd_data, W'((DB - 1) * 3 + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/channel_state_ram.md
CHANNEL_STATE_RAM -- requirements
Module: channel_state_ram

Interface
REQ-001 Parameter DEPTH, default 8: number of channel-state entries, legal range 2..256.
REQ-002 Parameter WIDTH, default 121: bits per entry, legal range 1..512.
REQ-003 Parameter LANE, default 8: bits per write-mask lane; MW = ceil(WIDTH/LANE); AW = max(1, clog2(DEPTH)).
REQ-004 clock  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 rd_en  in  1  read request.
REQ-007 rd_addr  in  AW  read entry index.
REQ-008 rd_data  out  WIDTH  read result, registered.
REQ-009 rd_valid  out  1  rd_data holds the result of a request issued on the previous cycle.
REQ-010 wr_en  in  1  write request.
REQ-011 wr_addr  in  AW  write entry index.
REQ-012 wr_data  in  WIDTH  write data.
REQ-013 wr_mask  in  MW  per-lane write enable; bit i covers data bits [i*LANE, min((i+1)*LANE, WIDTH)-1].
REQ-014 clear_start  in  1  single-cycle pulse that requests a zero-fill of all entries.
REQ-015 busy  out  1  zero-fill sequencer active.

Function
REQ-016 Storage is DEPTH x WIDTH, with one read port and one write port in the same clock domain.
REQ-017 Write: when wr_en=1, busy=0 and wr_addr<DEPTH, each lane with wr_mask bit = 1 takes wr_data at the edge; lanes with mask bit = 0 keep their contents.
REQ-018 Read: when rd_en=1 and busy=0, rd_data and rd_valid=1 appear on the following cycle (latency 1).
REQ-019 When no read is accepted, rd_valid=0 on the next cycle and rd_data holds its last value.
REQ-020 A read with rd_addr>=DEPTH is accepted and returns all-zero data with rd_valid=1.
REQ-021 A write with wr_addr>=DEPTH is ignored.
REQ-022 Same-cycle collision (rd_en, wr_en, equal in-range addresses) is write-first: rd_data equals the old entry with the masked lanes replaced by wr_data.
REQ-023 A read issued the cycle after a write to the same address returns the written value; no extra stall.
REQ-024 The sequencer has two states, IDLE and CLEAR, and a clear counter ccnt of AW bits.
REQ-025 IDLE -> CLEAR when clear_start=1; ccnt <= 0.
REQ-026 In CLEAR, each cycle writes all-zero to entry ccnt and increments ccnt; after writing entry DEPTH-1 the state returns to IDLE. CLEAR therefore lasts exactly DEPTH cycles.
REQ-027 busy=1 exactly while the state is CLEAR.
REQ-028 While busy=1, external writes are dropped, reads are not accepted (rd_valid=0 next cycle) and clear_start is ignored.
REQ-029 clear_start in the same cycle as rd_en or wr_en in IDLE: that read or write is serviced normally, then CLEAR begins next cycle.
REQ-030 The clear counter saturates its comparison at DEPTH-1, so it is correct for non-power-of-2 DEPTH.

Reset
REQ-031 While reset=0: state=CLEAR, ccnt=0, busy=1, rd_valid=0, rd_data=0.
REQ-032 After reset deasserts, the automatic zero-fill runs for DEPTH cycles, then busy=0; every entry reads 0 afterwards.
REQ-033 Reset asserted mid-CLEAR or mid-read aborts that activity immediately and restarts from REQ-031.
REQ-034 Entry contents themselves need no reset; REQ-032 guarantees zero before first use.

Verification
REQ-035 Reset release with defaults -> busy=1 for exactly 8 cycles, then 0; read of address 5 returns 0 with rd_valid one cycle after rd_en.
REQ-036 Write addr 3 = all-ones, mask 16'hFFFF; next cycle write addr 3 = 0, mask 16'h0001 -> read addr 3 returns bits[7:0]=0 and bits[120:8]=1.
REQ-037 Same-cycle rd/wr addr 2 (old entry 0), data all-ones, mask 16'h8000 -> rd_data = only bit 120 set; a later read also returns only bit 120 set.
REQ-038 Fill entries 0..7 with nonzero data, then pulse clear_start -> busy high for 8 cycles; writes and reads issued meanwhile are dropped (rd_valid=0); afterwards all entries read 0.
REQ-039 Assert reset at clear cycle 4 for 2 cycles -> busy stays 1; a full 8-cycle clear runs after release.
REQ-040 DEPTH=6: read addr 7 -> rd_data=0, rd_valid=1; write addr 6 leaves entries 0..5 unchanged; clear lasts 6 cycles.
